// File: rtl/wb_data_stage_if.sv
// MEM-to-WB bundle: the MEM-stage result and handshake going in, and the
// register-file write port, misalignment flag and retired count coming out.
interface wb_data_stage_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 32,
    parameter int OFF_W  = $clog2(DATA_W/8)
);
    logic              valid_in;
    logic              stall;
    logic              flush;
    logic [5:0]        op;
    logic [OFF_W-1:0]  byte_off;
    logic [DATA_W-1:0] dm_dout;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] pc;
    logic [15:0]       imm;
    logic [RA_W-1:0]   rd_in;
    logic              we_in;
    logic              rf_we;
    logic [RA_W-1:0]   rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              misalign;
    logic [CNT_W-1:0]  retired;

    modport master (
        output valid_in, stall, flush, op, byte_off, dm_dout, alu_out, pc, imm, rd_in, we_in,
        input  rf_we, rf_waddr, rf_wdata, misalign, retired
    );

    modport slave (
        input  valid_in, stall, flush, op, byte_off, dm_dout, alu_out, pc, imm, rd_in, we_in,
        output rf_we, rf_waddr, rf_wdata, misalign, retired
    );
endinterface

// File: rtl/wb_data_stage.sv
// Registered write-back stage: selects load/link/lui/ALU data, registers the
// register-file write port and counts retired instructions.
module wb_data_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int OFF_W  = $clog2(DATA_W/8),
    parameter int CNT_W  = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_data_stage_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam int NH = DATA_W / 16;
    localparam int NW = DATA_W / 32;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_LUI = 6'h0f;

    logic [7:0]  byte_lane [NB];
    logic [15:0] half_lane [NH];
    logic [31:0] word_lane [NW];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] word_sel;

    // Little-endian lanes: lane k sits at bits [k*width +: width].
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        assign byte_lane[gi] = bus.dm_dout[8*gi +: 8];
    end
    for (genvar gi = 0; gi < NH; gi++) begin : g_half
        assign half_lane[gi] = bus.dm_dout[16*gi +: 16];
    end
    for (genvar gi = 0; gi < NW; gi++) begin : g_word
        assign word_lane[gi] = bus.dm_dout[32*gi +: 32];
    end

    assign byte_sel = byte_lane[bus.byte_off];
    assign half_sel = half_lane[bus.byte_off[OFF_W-1:1]];

    if (NW == 1) begin : g_w1
        assign word_sel = word_lane[0];
    end else begin : g_wn
        assign word_sel = word_lane[bus.byte_off[OFF_W-1:2]];
    end

    logic [DATA_W-1:0] sel_data;
    logic              misaligned;

    always_comb begin
        sel_data   = bus.alu_out;
        misaligned = 1'b0;
        case (bus.op)
            OP_LB:  sel_data = DATA_W'($signed(byte_sel));
            OP_LBU: sel_data = DATA_W'(byte_sel);
            OP_LH: begin
                sel_data   = DATA_W'($signed(half_sel));
                misaligned = bus.byte_off[0];
            end
            OP_LHU: begin
                sel_data   = DATA_W'(half_sel);
                misaligned = bus.byte_off[0];
            end
            OP_LW: begin
                sel_data   = DATA_W'($signed(word_sel));
                misaligned = (bus.byte_off[1:0] != 2'b00);
            end
            OP_JAL:  sel_data = bus.pc + DATA_W'(8);
            OP_LUI:  sel_data = DATA_W'($signed({bus.imm, 16'h0000}));
            default: sel_data = bus.alu_out;
        endcase
    end

    logic              rf_we_reg;
    logic [RA_W-1:0]   rf_waddr_reg;
    logic [DATA_W-1:0] rf_wdata_reg;
    logic              misalign_reg;
    logic [CNT_W-1:0]  retired_reg;
    logic              retire;

    assign retire = bus.valid_in & ~bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
            misalign_reg <= 1'b0;
            retired_reg  <= '0;
        end else if (bus.stall) begin
            // Drop the strobe so a held result is never written twice.
            rf_we_reg <= 1'b0;
        end else begin
            rf_waddr_reg <= bus.rd_in;
            rf_wdata_reg <= sel_data;
            rf_we_reg    <= retire & bus.we_in & (bus.rd_in != '0);
            misalign_reg <= retire & misaligned;
            retired_reg  <= retired_reg + CNT_W'(retire);
        end
    end

    assign bus.rf_we    = rf_we_reg;
    assign bus.rf_waddr = rf_waddr_reg;
    assign bus.rf_wdata = rf_wdata_reg;
    assign bus.misalign = misalign_reg;
    assign bus.retired  = retired_reg;
endmodule

// File: tb/tb_wb_data_stage.sv
// Directed bench for wb_data_stage: load/link/lui/ALU select, misalignment,
// stall/flush, r0 suppression, counter wrap (CNT_W=4 copy) and async reset.
module tb_wb_data_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_data_stage_if #(.DATA_W(32), .RA_W(5), .CNT_W(32)) bus ();
    wb_data_stage_if #(.DATA_W(32), .RA_W(5), .CNT_W(4))  sbus ();

    wb_data_stage #(.DATA_W(32), .RA_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    wb_data_stage #(.DATA_W(32), .RA_W(5), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .bus(sbus.slave)
    );

    // The narrow-counter copy sees exactly the same stimulus.
    assign sbus.valid_in = bus.valid_in;
    assign sbus.stall    = bus.stall;
    assign sbus.flush    = bus.flush;
    assign sbus.op       = bus.op;
    assign sbus.byte_off = bus.byte_off;
    assign sbus.dm_dout  = bus.dm_dout;
    assign sbus.alu_out  = bus.alu_out;
    assign sbus.pc       = bus.pc;
    assign sbus.imm      = bus.imm;
    assign sbus.rd_in    = bus.rd_in;
    assign sbus.we_in    = bus.we_in;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic set_in(input logic [5:0] o, input logic [1:0] off, input logic [31:0] dout,
                          input logic [31:0] alu, input logic [31:0] pcv, input logic [15:0] im,
                          input logic [4:0] rd, input logic we, input logic vld,
                          input logic stl, input logic fl);
        bus.op       = o;
        bus.byte_off = off;
        bus.dm_dout  = dout;
        bus.alu_out  = alu;
        bus.pc       = pcv;
        bus.imm      = im;
        bus.rd_in    = rd;
        bus.we_in    = we;
        bus.valid_in = vld;
        bus.stall    = stl;
        bus.flush    = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with an active instruction on the inputs.
        set_in(6'h24, 2'd0, 32'h11223380, 32'h0, 32'h0, 16'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        step();
        check("reset_we", bus.rf_we, 0);
        check("reset_waddr", bus.rf_waddr, 0);
        check("reset_wdata", bus.rf_wdata, 0);
        check("reset_misalign", bus.misalign, 0);
        check("reset_retired", bus.retired, 0);
        rst_n = 1'b1;

        step(); exp_ret++;
        check("lbu_we", bus.rf_we, 1);
        check("lbu_waddr", bus.rf_waddr, 5);
        check("lbu_wdata", bus.rf_wdata, 32'h00000080);
        check("lbu_retired", bus.retired, exp_ret);

        set_in(6'h20, 2'd0, 32'h11223380, 32'h0, 32'h0, 16'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); exp_ret++;
        check("lb_wdata", bus.rf_wdata, 32'hFFFFFF80);
        check("lb_waddr", bus.rf_waddr, 6);

        set_in(6'h21, 2'd2, 32'h11223380, 32'h0, 32'h0, 16'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); exp_ret++;
        check("lh_off2_wdata", bus.rf_wdata, 32'h00001122);
        check("lh_off2_misalign", bus.misalign, 0);

        set_in(6'h25, 2'd2, 32'h80000000, 32'h0, 32'h0, 16'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); exp_ret++;
        check("lhu_wdata", bus.rf_wdata, 32'h00008000);

        set_in(6'h21, 2'd2, 32'h80000000, 32'h0, 32'h0, 16'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); exp_ret++;
        check("lh_sext_wdata", bus.rf_wdata, 32'hFFFF8000);

        set_in(6'h03, 2'd0, 32'h0, 32'h0, 32'h00400010, 16'h0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); exp_ret++;
        check("jal_wdata", bus.rf_wdata, 32'h00400018);
        check("jal_waddr", bus.rf_waddr, 31);

        set_in(6'h0f, 2'd0, 32'h0, 32'h0, 32'h0, 16'hABCD, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); exp_ret++;
        check("lui_wdata", bus.rf_wdata, 32'hABCD0000);

        set_in(6'h00, 2'd0, 32'h0, 32'h00001234, 32'h0, 16'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); exp_ret++;
        check("add_wdata", bus.rf_wdata, 32'h00001234);
        check("add_retired", bus.retired, exp_ret);

        set_in(6'h23, 2'd2, 32'h11223380, 32'h0, 32'h0, 16'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); exp_ret++;
        check("lw_mis_misalign", bus.misalign, 1);
        check("lw_mis_we", bus.rf_we, 1);
        check("lw_mis_wdata", bus.rf_wdata, 32'h11223380);

        set_in(6'h21, 2'd1, 32'h11223380, 32'h0, 32'h0, 16'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); exp_ret++;
        check("lh_off1_misalign", bus.misalign, 1);
        check("lh_off1_wdata", bus.rf_wdata, 32'h00003380);

        set_in(6'h00, 2'd1, 32'h0, 32'h00000055, 32'h0, 16'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); exp_ret++;
        check("after_mis_misalign", bus.misalign, 0);
        check("cap_we", bus.rf_we, 1);
        check("cap_wdata", bus.rf_wdata, 32'h55);

        // Stall for three edges with different data presented.
        set_in(6'h00, 2'd0, 32'h0, 32'h00000066, 32'h0, 16'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d_we", i), bus.rf_we, 0);
            check($sformatf("stall%0d_wdata", i), bus.rf_wdata, 32'h55);
            check($sformatf("stall%0d_waddr", i), bus.rf_waddr, 7);
            check($sformatf("stall%0d_retired", i), bus.retired, exp_ret);
        end

        // Flush together with stall: nothing captured.
        set_in(6'h00, 2'd0, 32'h0, 32'h00000077, 32'h0, 16'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        check("stallflush_wdata", bus.rf_wdata, 32'h55);
        check("stallflush_retired", bus.retired, exp_ret);

        // Stall drops, flush still high: killed.
        bus.stall = 1'b0;
        step();
        check("flush_we", bus.rf_we, 0);
        check("flush_retired", bus.retired, exp_ret);

        set_in(6'h00, 2'd0, 32'h0, 32'h00000099, 32'h0, 16'h0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(); exp_ret++;
        check("r0_we", bus.rf_we, 0);
        check("r0_retired", bus.retired, exp_ret);

        set_in(6'h00, 2'd0, 32'h0, 32'h00000099, 32'h0, 16'h0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("invalid_we", bus.rf_we, 0);
        check("invalid_retired", bus.retired, exp_ret);

        // Counter wrap on the CNT_W=4 copy.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        check("rst_retired", bus.retired, 0);
        set_in(6'h00, 2'd0, 32'h0, 32'h00000042, 32'h0, 16'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) step();
        check("wrap_small_retired", sbus.retired, 1);
        check("wrap_main_retired", bus.retired, 17);
        check("pending_we", bus.rf_we, 1);

        // Asynchronous reset between edges clears everything at once.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_we", bus.rf_we, 0);
        check("async_wdata", bus.rf_wdata, 0);
        check("async_waddr", bus.rf_waddr, 0);
        check("async_retired", bus.retired, 0);
        check("async_small_retired", sbus.retired, 0);
        #2;
        rst_n = 1'b1;

        set_in(6'h24, 2'd3, 32'h11223380, 32'h0, 32'h0, 16'h0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("post_rst_we", bus.rf_we, 1);
        check("post_rst_wdata", bus.rf_wdata, 32'h00000011);
        check("post_rst_retired", bus.retired, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_data_stage.md
Name: wb_data_stage

Overview:
- Registered write-back stage of the pipelined CPU.
- Takes MEM-stage results (ALU result, data-memory word, PC, immediate) and produces the register-file write port: address, data and one-cycle write strobe.
- Generalises the combinational RF write-data select:
  - parametrised data width;
  - signed and unsigned byte/halfword loads;
  - stall/flush handshake;
  - misalignment flag;
  - retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width; must be 32 or 64.
- RA_W, 5, register-file address width.
- OFF_W, $clog2(DATA_W/8), byte-offset width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  MEM stage presents a valid instruction
- stall  in  1  hold the stage; no capture, no write
- flush  in  1  kill the instruction being captured
- op  in  6  MIPS primary opcode of the instruction
- byte_off  in  OFF_W  low address bits of the load
- dm_dout  in  DATA_W  data-memory read word
- alu_out  in  DATA_W  ALU result
- pc  in  DATA_W  instruction PC
- imm  in  16  instruction immediate
- rd_in  in  RA_W  destination register
- we_in  in  1  instruction writes the register file
- rf_we  out  1  register-file write strobe
- rf_waddr  out  RA_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- misalign  out  1  registered misaligned-load flag
- retired  out  CNT_W  count of valid instructions retired

Behaviour:
- Reset (async, rst_n=0): all outputs and internal registers are 0 immediately; no write is issued.
- Data select, combinational on the inputs, selected by op:
  - 0x20 lb: byte at byte_off, sign-extended.
  - 0x24 lbu: byte at byte_off, zero-extended.
  - 0x21 lh: halfword at byte_off[OFF_W-1:1], sign-extended.
  - 0x25 lhu: halfword at byte_off[OFF_W-1:1], zero-extended.
  - 0x23 lw: low 32 bits of dm_dout at the word selected by byte_off[OFF_W-1:2] (for DATA_W=64), sign-extended to DATA_W.
  - 0x03 jal: pc+8 (link past the delay slot), modulo 2^DATA_W.
  - 0x0f lui: {imm,16'h0}, sign-extended to DATA_W.
  - All other opcodes: alu_out.
- Byte lanes are little-endian: lane k is dm_dout[8k+7:8k].
- Misalignment:
  - lh/lhu with byte_off[0]=1, or lw with byte_off[1:0]!=0, is misaligned.
  - The data still uses the lane selection above (low bits ignored).
  - misalign is set for that instruction's output cycle.
- Capture, at posedge clk with stall=0:
  - rf_waddr <= rd_in;
  - rf_wdata <= selected data;
  - rf_we <= valid_in & we_in & ~flush & (rd_in!=0);
  - misalign <= valid_in & ~flush & misaligned.
- Latency: exactly 1 cycle from capture edge to rf_we high.
- rf_we is high for at most one cycle per instruction.
- stall=1:
  - rf_waddr, rf_wdata and misalign hold their values;
  - rf_we is forced 0 on the next edge, so a stalled result is never written twice;
  - retired does not change.
- flush with stall both 1: stall wins, nothing is captured. The flushed instruction is killed when it is captured after stall falls, provided flush is still asserted then.
- Writes to register 0 are suppressed, but they still count as retired if valid.
- retired increments by 1 on each non-stalled edge with valid_in=1 and flush=0, whether or not we_in is set. It wraps from 2^CNT_W-1 to 0 silently.
- Reset asserted mid-operation: any pending write is dropped and the counter clears. The first capture after rst_n rises is a normal capture.

Test Plan:
- Reset with inputs active → all outputs 0. Release rst_n, capture lbu with dm_dout=0x11223380, byte_off=0, rd=5 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x00000080, retired=1.
- Same word, lb at byte_off=0 → rf_wdata=0xFFFFFF80. lh at byte_off=2 → 0x00001122. lhu with dm_dout=0x8000_0000, byte_off=2 → 0x00008000.
- jal at pc=0x00400010 with rd=31 → rf_wdata=0x00400018. lui with imm=0xABCD → 0xABCD0000. Add opcode 0x00 with alu_out=0x1234 → 0x1234.
- lw at byte_off=2 → misalign=1 for one cycle and rf_we=1. lh at byte_off=1 → misalign=1.
- Hold stall high 3 cycles after a capture → rf_we high only on the first cycle, rf_wdata stable, retired unchanged. Then flush=1 with valid_in=1 → rf_we=0, retired unchanged. Write to rd=0 → rf_we=0, retired+1.
- CNT_W=4: retire 17 valid instructions → retired=1. Assert rst_n=0 asynchronously mid-cycle → outputs 0 before the next clock edge.
